// File: rtl/adder_arbiter_pkg.sv
// Shared state encodings and widths for the adder arbiter.
// Optional stats counter enabled by defining ADDER_ARB_STATS_EN.
package adder_arbiter_pkg;

    localparam int STATE_W = 2;
    localparam int CNT_W   = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible requester at or
// after Ptr (mod NREQ), ignoring requesters set in mask.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] Req,
    input  logic [NREQ-1:0] mask,
    input  logic [IW-1:0]   Ptr,
    output logic            Valid,
    output logic [IW-1:0]   Index
);

    logic [NREQ-1:0] elig;
    int              j;

    assign elig = Req & ~mask;

    // Scan farthest-first so the nearest eligible slot is the last write.
    always_comb begin
        Valid = 1'b0;
        Index = '0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(Ptr) + k) % NREQ;
            if (elig[j]) begin
                Valid = 1'b1;
                Index = IW'(j);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered W-bit adder among NREQ requesters.
// Define ADDER_ARB_STATS_EN to enable the saturating Txn_Count counter.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IW   = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ*W-1:0] A_Bus,
    input  logic [NREQ*W-1:0] B_Bus,
    output logic [NREQ-1:0]   Grant,
    output logic [NREQ-1:0]   Done,
    output logic [W-1:0]      Result,
    output logic              Result_Ovf,
    output logic              Busy,
    output logic              Add_En,
    output logic [W-1:0]      Add_A,
    output logic [W-1:0]      Add_B,
    input  logic [W-1:0]      Add_Sum,
    input  logic              Add_Overflow,
    output logic [CNT_W-1:0]  Txn_Count
);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   g_idx;
    logic [IW-1:0]   g_next;
    logic            in_resp;
    logic [IW-1:0]   pick_ptr;
    logic [NREQ-1:0] pick_mask;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_oh;

    assign g_next  = (int'(g_idx) == NREQ - 1) ? '0 : g_idx + IW'(1);
    assign in_resp = (state == ST_RESP);

    // In RESP the scan starts past the current grantee, which is masked.
    assign pick_ptr  = in_resp ? g_next : ptr;
    assign pick_mask = in_resp ? Grant : '0;
    assign pick_oh   = NREQ'(1) << pick_idx;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .Req   (Req),
        .mask  (pick_mask),
        .Ptr   (pick_ptr),
        .Valid (pick_valid),
        .Index (pick_idx)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            g_idx      <= '0;
            Grant      <= '0;
            Done       <= '0;
            Result     <= '0;
            Result_Ovf <= 1'b0;
            Busy       <= 1'b0;
            Add_En     <= 1'b0;
            Add_A      <= '0;
            Add_B      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        Add_A  <= A_Bus[pick_idx*W +: W];
                        Add_B  <= B_Bus[pick_idx*W +: W];
                        g_idx  <= pick_idx;
                        Grant  <= pick_oh;
                        Add_En <= 1'b1;
                        Busy   <= 1'b1;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    Add_En <= 1'b0;
                    state  <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    Result     <= Add_Sum;
                    Result_Ovf <= Add_Overflow;
                    Done       <= Grant;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    Done <= '0;
                    ptr  <= g_next;
                    if (pick_valid) begin
                        Add_A  <= A_Bus[pick_idx*W +: W];
                        Add_B  <= B_Bus[pick_idx*W +: W];
                        g_idx  <= pick_idx;
                        Grant  <= pick_oh;
                        Add_En <= 1'b1;
                        state  <= ST_ISSUE;
                    end else begin
                        Grant <= '0;
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADDER_ARB_STATS_EN
    logic [CNT_W-1:0] txn_count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            txn_count <= '0;
        end else if (in_resp && txn_count != CNT_MAX) begin
            txn_count <= txn_count + CNT_W'(1);
        end
    end

    assign Txn_Count = txn_count;
`else
    assign Txn_Count = '0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter with a behavioural registered adder.
// Expects Txn_Count saturation only when ADDER_ARB_STATS_EN is defined.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IW   = 2;

    typedef struct packed {
        logic [NREQ-1:0] done;
        logic [W-1:0]    res;
        logic            ovf;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_bus;
    logic [NREQ*W-1:0] b_bus;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      result;
    logic              result_ovf;
    logic              busy;
    logic              add_en;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_sum;
    logic              add_ovf;
    logic [7:0]        txn_count;

    exp_t sb[$];
    int   done_cyc_q[$];
    int   cyc;
    int   compared;
    int   mismatched;

    adder_arbiter #(
        .NREQ (NREQ),
        .W    (W),
        .IW   (IW)
    ) dut (
        .Clk          (clk),
        .Reset        (rst),
        .Req          (req),
        .A_Bus        (a_bus),
        .B_Bus        (b_bus),
        .Grant        (grant),
        .Done         (done),
        .Result       (result),
        .Result_Ovf   (result_ovf),
        .Busy         (busy),
        .Add_En       (add_en),
        .Add_A        (add_a),
        .Add_B        (add_b),
        .Add_Sum      (add_sum),
        .Add_Overflow (add_ovf),
        .Txn_Count    (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared registered adder, deliberately unreset.
    always @(posedge clk) begin
        if (add_en) begin
            {add_ovf, add_sum} <= {1'b0, add_a} + {1'b0, add_b};
        end
    end

    task automatic push_exp(input int idx, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        exp_t        e;
        logic [W:0]  s;
        s      = {1'b0, a} + {1'b0, b};
        e.done = NREQ'(1) << idx;
        e.res  = s[W-1:0];
        e.ovf  = s[W];
        sb.push_back(e);
    endtask

    task automatic set_ops(input int idx, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        a_bus[idx*W +: W] = a;
        b_bus[idx*W +: W] = b;
    endtask

    // Scoreboard pop on every Done pulse, sampled on the falling edge.
    task automatic sb_sample();
        exp_t e;
        if (done !== '0) begin
            done_cyc_q.push_back(cyc);
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL sb_unexpected_done: got Done=%b, expected none", done);
            end else begin
                e = sb.pop_front();
                if ({done, result, result_ovf} !== {e.done, e.res, e.ovf}) begin
                    mismatched++;
                    $display("FAIL sb_done: got Done=%b Result=%h Ovf=%b, expected Done=%b Result=%h Ovf=%b",
                             done, result, result_ovf, e.done, e.res, e.ovf);
                end
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            sb_sample();
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            cycles(1);
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        done_cyc_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({grant, done, busy, add_en, add_a, add_b, result, result_ovf} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got G=%b D=%b B=%b E=%b A=%h B=%h R=%h O=%b, expected all 0",
                     grant, done, busy, add_en, add_a, add_b, result, result_ovf);
        end
        compared++;
        if (txn_count !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_count: got %h, expected 00", txn_count);
        end
    endtask

    task automatic test_single();
        int c0;
        do_reset();
        set_ops(0, 4'h9, 4'h8);
        push_exp(0, 4'h9, 4'h8);
        req = 4'b0001;
        c0  = cyc;
        cycles(1);
        compared++;
        if ({add_en, add_a, add_b, grant, busy} !== {1'b1, 4'h9, 4'h8, 4'b0001, 1'b1}) begin
            mismatched++;
            $display("FAIL single_issue: got En=%b A=%h B=%h G=%b Busy=%b, expected 1 9 8 0001 1",
                     add_en, add_a, add_b, grant, busy);
        end
        req = '0;
        cycles(1);
        compared++;
        if ({add_en, busy} !== 2'b01) begin
            mismatched++;
            $display("FAIL single_capture: got En=%b Busy=%b, expected 0 1", add_en, busy);
        end
        cycles(1);
        compared++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != c0 + 3) begin
            mismatched++;
            $display("FAIL single_latency: got %0d dones (first at +%0d), expected 1 at +3",
                     done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] - c0 : -1);
        end
        cycles(2);
        compared++;
        if ({busy, grant, done, result, result_ovf} !== {1'b0, 4'b0000, 4'b0000, 4'h1, 1'b1}) begin
            mismatched++;
            $display("FAIL single_idle_hold: got Busy=%b G=%b D=%b R=%h O=%b, expected 0 0000 0000 1 1",
                     busy, grant, done, result, result_ovf);
        end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, W'(4 * i + 3), W'(i + 5));
        for (int i = 0; i < NREQ; i++) push_exp(i, W'(4 * i + 3), W'(i + 5));
        req = 4'b1111;
        cycles(10);
        req = '0;
        wait_drain(20);
        compared++;
        if (done_cyc_q.size() != 4) begin
            mismatched++;
            $display("FAIL all_four_count: got %0d dones, expected 4", done_cyc_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                if (done_cyc_q[i] - done_cyc_q[i-1] != 3) begin
                    mismatched++;
                    $display("FAIL all_four_spacing: got %0d cycles, expected 3",
                             done_cyc_q[i] - done_cyc_q[i-1]);
                end
            end
        end
        cycles(2);
        compared++;
        if ({busy, grant} !== 5'b0) begin
            mismatched++;
            $display("FAIL all_four_idle: got Busy=%b G=%b, expected 0 0000", busy, grant);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        set_ops(0, 4'h3, 4'h4);
        set_ops(2, 4'hA, 4'h9);
        set_ops(1, 4'hF, 4'hF);
        set_ops(3, 4'hF, 4'hF);
        for (int i = 0; i < 2; i++) begin
            push_exp(0, 4'h3, 4'h4);
            push_exp(2, 4'hA, 4'h9);
        end
        req = 4'b0101;
        cycles(10);
        req = '0;
        wait_drain(20);
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_ops(0, 4'hF, 4'hF);
        req = 4'b0001;
        cycles(2);
        rst = 1'b1;
        req = '0;
        cycles(1);
        compared++;
        if ({busy, grant, done, add_en, result, result_ovf} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid_state: got Busy=%b G=%b D=%b En=%b R=%h O=%b, expected all 0",
                     busy, grant, done, add_en, result, result_ovf);
        end
        rst = 1'b0;
        cycles(3);
        compared++;
        if (done_cyc_q.size() != 0) begin
            mismatched++;
            $display("FAIL reset_mid_dropped: got %0d dones, expected 0", done_cyc_q.size());
        end
        set_ops(1, 4'h3, 4'h4);
        push_exp(1, 4'h3, 4'h4);
        req = 4'b0010;
        cycles(1);
        req = '0;
        wait_drain(10);
        cycles(1);
        compared++;
        if ({result, result_ovf} !== {4'h7, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_mid_result: got R=%h O=%b, expected 7 0", result, result_ovf);
        end
    endtask

    task automatic test_latched();
        do_reset();
        set_ops(0, 4'h5, 4'h1);
        push_exp(0, 4'h5, 4'h1);
        req = 4'b0001;
        cycles(1);
        set_ops(0, 4'hF, 4'h1);
        req = '0;
        compared++;
        if (add_a !== 4'h5) begin
            mismatched++;
            $display("FAIL latched_add_a: got %h, expected 5", add_a);
        end
        wait_drain(10);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_cnt;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, W'(i * 5 + 2), W'(13 - 2 * i));
        for (int k = 0; k < 300; k++) push_exp(k % NREQ, W'((k % NREQ) * 5 + 2), W'(13 - 2 * (k % NREQ)));
        req = 4'b1111;
        cycles(898);
        req = '0;
        wait_drain(20);
        cycles(1);
`ifdef ADDER_ARB_STATS_EN
        exp_cnt = 8'hFF;
`else
        exp_cnt = 8'h00;
`endif
        compared++;
        if (txn_count !== exp_cnt) begin
            mismatched++;
            $display("FAIL b2b_count: got %h, expected %h", txn_count, exp_cnt);
        end
        compared++;
        if (done_cyc_q.size() != 300) begin
            mismatched++;
            $display("FAIL b2b_dones: got %0d, expected 300", done_cyc_q.size());
        end
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        a_bus      = '0;
        b_bus      = '0;
        cyc        = 0;
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_reset_mid();
        test_latched();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
